relu_expand8to32: RTL and testbench

RELU_EXPAND8TO32 -- requirements
Module: relu_expand8to32

---
 rtl/relu_expand8to32.sv | 92 +++++++++
 tb/tb_relu_expand8to32.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/relu_expand8to32.sv
// ReLU plus fixed-point expansion of signed 8-bit activations to 32 bits, in a 2-stage valid/ready pipeline.
// Optional build macro RELU_EXPAND_ROUND_EN adds a half-LSB rounding offset after the shift.
module relu_expand8to32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  din_act,
    input  logic [4:0]  cut,
    input  logic [15:0] cfg_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout_exp,
    output logic        dout_sat,
    output logic        out_last
);

    logic        s1_valid;
    logic [7:0]  s1_act;
    logic [4:0]  s1_cut;
    logic        s2_valid;
    logic        s2_load;
    logic [15:0] elem_cnt;
    logic [15:0] last_idx;
    logic [38:0] shifted;
    logic [38:0] sum;
    logic        sat;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // A channel length of zero behaves as a length of one.
    assign last_idx = (cfg_len == 16'd0) ? 16'd0 : cfg_len - 16'd1;
    assign out_last = s2_valid && (elem_cnt == last_idx);

    always_comb begin
        shifted = {32'd0, s1_act[6:0]} << s1_cut;
        sum     = shifted;
`ifdef RELU_EXPAND_ROUND_EN
        if (!s1_act[7] && (s1_act[6:0] != 7'd0) && (s1_cut != 5'd0)) begin
            sum = shifted + (39'd1 << (s1_cut - 5'd1));
        end
`endif
        sat = |sum[38:31];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_act   <= 8'd0;
            s1_cut   <= 5'd0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_act <= din_act;
                s1_cut <= cut;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            dout_exp <= 32'd0;
            dout_sat <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_act[7]) begin
                    dout_exp <= 32'd0;
                    dout_sat <= 1'b0;
                end else if (sat) begin
                    dout_exp <= 32'h7FFF_FFFF;
                    dout_sat <= 1'b1;
                end else begin
                    dout_exp <= sum[31:0];
                    dout_sat <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt <= 16'd0;
        end else if (s2_valid && out_ready) begin
            elem_cnt <= out_last ? 16'd0 : elem_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_relu_expand8to32.sv
// Directed bench for relu_expand8to32: vector table for single elements plus streaming,
// backpressure, channel-length and mid-stream reset sequences.
module tb_relu_expand8to32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  din_act;
    logic [4:0]  cut;
    logic [15:0] cfg_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout_exp;
    logic        dout_sat;
    logic        out_last;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  din;
        logic [4:0]  cut;
        logic [31:0] expPlain;
        logic        satPlain;
        logic [31:0] expRound;
        logic        satRound;
    } vec_t;

    vec_t vecs[12];

    relu_expand8to32 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din_act(din_act), .cut(cut), .cfg_len(cfg_len), .out_valid(out_valid),
        .out_ready(out_ready), .dout_exp(dout_exp), .dout_sat(dout_sat), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] streamValue(input int k);
`ifdef RELU_EXPAND_ROUND_EN
        return (32'(k) << 4) + 32'd8;
`else
        return 32'(k) << 4;
`endif
    endfunction

    // Streams n elements (values 1..n, cut=4); out_ready is held low for cycles stallLo..stallHi.
    task automatic applyStimulus(input int n, input int stallLo, input int stallHi,
                                 input logic [15:0] len, input int startIdx, input bit expectBlock);
        int sent = 0;
        int rcvd = 0;
        int c = 0;
        int lenEff;
        bit sawBlock = 0;
        bit hadStall = 0;
        logic [31:0] heldExp = 0;
        logic heldLast = 0;
        lenEff = (len == 16'd0) ? 1 : int'(len);
        cfg_len = len;
        while (rcvd < n && c < 100) begin
            @(negedge clk);
            in_valid  = (sent < n);
            din_act   = 8'(sent + 1);
            cut       = 5'd4;
            out_ready = !(c >= stallLo && c <= stallHi);
            #1;
            if (hadStall) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_hold_exp", dout_exp, heldExp);
                checkOutput("stall_hold_last", 32'(out_last), 32'(heldLast));
            end
            if (!in_ready) sawBlock = 1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream_exp[%0d]", rcvd), dout_exp, streamValue(rcvd + 1));
                checkOutput($sformatf("stream_last[%0d]", rcvd), 32'(out_last),
                            32'(((startIdx + rcvd + 1) % lenEff) == 0));
                rcvd++;
            end
            hadStall = out_valid && !out_ready;
            heldExp  = dout_exp;
            heldLast = out_last;
            @(posedge clk);
            c++;
        end
        checkOutput("stream_count", 32'(rcvd), 32'(n));
        if (expectBlock) checkOutput("in_ready_dropped", 32'(sawBlock), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{8'h25, 5'd16, 32'h0025_0000, 1'b0, 32'h0025_8000, 1'b0};
        vecs[1]  = '{8'h7F, 5'd28, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
        vecs[2]  = '{8'h01, 5'd30, 32'h4000_0000, 1'b0, 32'h6000_0000, 1'b0};
        vecs[3]  = '{8'h85, 5'd16, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{8'h00, 5'd5,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{8'h01, 5'd31, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
        vecs[6]  = '{8'h7F, 5'd0,  32'h0000_007F, 1'b0, 32'h0000_007F, 1'b0};
        vecs[7]  = '{8'h3F, 5'd25, 32'h7E00_0000, 1'b0, 32'h7F00_0000, 1'b0};
        vecs[8]  = '{8'h40, 5'd25, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
        vecs[9]  = '{8'hFF, 5'd3,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[10] = '{8'h03, 5'd1,  32'h0000_0006, 1'b0, 32'h0000_0007, 1'b0};
        vecs[11] = '{8'h7F, 5'd24, 32'h7F00_0000, 1'b0, 32'h7F80_0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; din_act = 8'd0; cut = 5'd0; cfg_len = 16'd0; out_ready = 1'b0;
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_dout_exp", dout_exp, 32'd0);
        checkOutput("reset_dout_sat", 32'(dout_sat), 32'd0);
        checkOutput("reset_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; din_act = vecs[i].din; cut = vecs[i].cut; out_ready = 1'b1;
            #1 checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_not_early", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
`ifdef RELU_EXPAND_ROUND_EN
            checkOutput($sformatf("vec%0d_exp", i), dout_exp, vecs[i].expRound);
            checkOutput($sformatf("vec%0d_sat", i), 32'(dout_sat), 32'(vecs[i].satRound));
`else
            checkOutput($sformatf("vec%0d_exp", i), dout_exp, vecs[i].expPlain);
            checkOutput($sformatf("vec%0d_sat", i), 32'(dout_sat), 32'(vecs[i].satPlain));
`endif
            checkOutput($sformatf("vec%0d_last", i), 32'(out_last), 32'd1);
        end
        @(posedge clk);

        applyStimulus(5, 3, 6, 16'd0, 0, 1'b1);
        applyStimulus(9, -1, -1, 16'd4, 0, 1'b0);
        applyStimulus(1, -1, -1, 16'd4, 1, 1'b0);

        // Park two elements in the pipe, then reset while they are in flight.
        @(negedge clk);
        in_valid = 1'b1; din_act = 8'h11; cut = 5'd0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        din_act = 8'h12;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 checkOutput("preflush_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4, -1, -1, 16'd4, 0, 1'b0);
        #1 checkOutput("drained_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
